// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction-memory port, datapath control and status bundle
// master = sequencer (drives fetch request, datapath controls, status); slave = memory/datapath side
interface alu_sequencer_if;
  logic [7:0] imem_addr;
  logic imem_req;
  logic [15:0] imem_data;
  logic imem_valid;
  logic [7:0] flags;
  logic [2:0] alu_op, ri_a, ri_b, ri_d;
  logic rw, wen;
  logic [7:0] wd;
  logic halted, illegal;
  modport master (
    output imem_addr, imem_req, alu_op, ri_a, ri_b, ri_d, rw, wen, wd, halted, illegal,
    input imem_data, imem_valid, flags
  );
  modport slave (
    input imem_addr, imem_req, alu_op, ri_a, ri_b, ri_d, rw, wen, wd, halted, illegal,
    output imem_data, imem_valid, flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute control unit driving the register/ALU datapath
// ports: clk, rst (sync, active-high); bus (master): imem_addr/imem_req/imem_data/imem_valid fetch port,
// flags in, alu_op/ri_a/ri_b/ri_d/rw/wen/wd datapath controls, halted/illegal status
module alu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input logic clk,
  input logic rst,
  alu_sequencer_if.master bus
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;
  state_t state;
  logic [7:0] pc, target;
  logic [3:0] op, dop;
  logic d_alu, d_ldi, bad, taken;
  assign dop = bus.imem_data[15:12];
  assign d_alu = dop == 4'h1 || dop == 4'h3;
  assign d_ldi = dop == 4'h2;
  assign bad = op inside {[4'h7:4'hE]};
  assign taken = op == 4'h4 || (op == 4'h5 && bus.flags[0]) || (op == 4'h6 && bus.flags[1]);
  assign bus.imem_addr = pc;
  // gated by rst so the request stays low for the whole reset cycle
  assign bus.imem_req = state == FETCH && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      op <= 4'h0;
      target <= 8'h00;
      bus.alu_op <= 3'd0;
      bus.ri_a <= 3'd0;
      bus.ri_b <= 3'd0;
      bus.ri_d <= 3'd0;
      bus.wd <= 8'h00;
      bus.wen <= 1'b0;
      bus.rw <= 1'b0;
      bus.halted <= 1'b0;
      bus.illegal <= 1'b0;
    end else begin
      case (state)
        // fields are decoded straight from the fetched word so they are valid throughout DECODE
        FETCH: if (bus.imem_valid) begin
          op <= dop;
          target <= bus.imem_data[7:0];
          bus.alu_op <= d_alu ? bus.imem_data[11:9] : 3'd0;
          bus.ri_d <= d_alu ? bus.imem_data[8:6] : d_ldi ? bus.imem_data[10:8] : 3'd0;
          bus.ri_a <= d_alu ? bus.imem_data[5:3] : 3'd0;
          bus.ri_b <= d_alu ? bus.imem_data[2:0] : 3'd0;
          bus.wd <= d_ldi ? bus.imem_data[7:0] : 8'h00;
          bus.wen <= d_ldi;
          state <= DECODE;
        end
        DECODE: begin
          bus.rw <= op == 4'h1 || op == 4'h2;
          state <= EXECUTE;
        end
        EXECUTE: begin
          bus.rw <= 1'b0;
          if (op == 4'hF || bad) begin
            bus.halted <= 1'b1;
            bus.illegal <= bad;
            state <= HALT;
          end else begin
            pc <= taken ? target : pc + 8'd1;
            state <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scoreboard bench for alu_sequencer
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_sequencer_if bus();
  alu_sequencer #(.RESET_PC(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic wen;
    logic [2:0] op, rd, ra, rb;
    logic [7:0] wd;
  } wr_t;
  wr_t q[$];
  logic [15:0] mem [256];
  int lat [256];
  int wait_cnt = 0;
  int checks = 0, errors = 0, rw_cnt = 0;
  logic prev_rw = 1'b0;
  assign bus.imem_data = mem[bus.imem_addr];
  assign bus.imem_valid = bus.imem_req && wait_cnt >= lat[bus.imem_addr];
  always @(posedge clk) wait_cnt <= (bus.imem_req && !bus.imem_valid) ? wait_cnt + 1 : 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic next_fetch(input logic [7:0] a, input string tag);
    int n = 0;
    while (bus.imem_req && n < 60) begin @(negedge clk); n++; end
    while (!bus.imem_req && n < 60) begin @(negedge clk); n++; end
    chk(tag, {bus.imem_req, bus.imem_addr}, {1'b1, a});
  endtask
  task automatic chk_reset(input string tag);
    chk(tag, {bus.imem_req, bus.rw, bus.wen, bus.wd, bus.alu_op, bus.ri_a, bus.ri_b, bus.ri_d,
              bus.halted, bus.illegal, bus.imem_addr}, 64'd0);
  endtask
  always @(negedge clk) begin
    if (bus.rw) begin
      rw_cnt++;
      chk("rw_single_cycle", {63'd0, prev_rw}, 64'd0);
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL rw_unexpected: got rw=1 with no pending write, expected rw=0");
      end
      if (q.size() > 0) chk("write_fields", {bus.wen, bus.alu_op, bus.ri_d, bus.ri_a, bus.ri_b, bus.wd}, q.pop_front());
    end
    prev_rw = bus.rw;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 16'h0000; lat[i] = 0; end
    mem[8'h00] = 16'h235A;
    mem[8'h01] = 16'h0000;
    mem[8'h02] = 16'h1453; lat[8'h02] = 4;
    mem[8'h03] = 16'h320A;
    mem[8'h04] = 16'h5040;
    mem[8'h40] = 16'h320A;
    mem[8'h41] = 16'h5040;
    mem[8'h42] = 16'h6080;
    mem[8'h80] = 16'h40FF;
    mem[8'hFF] = 16'h0000;
    q.push_back('{wen: 1'b1, op: 3'd0, rd: 3'd3, ra: 3'd0, rb: 3'd0, wd: 8'h5A});
    q.push_back('{wen: 1'b0, op: 3'd2, rd: 3'd1, ra: 3'd2, rb: 3'd3, wd: 8'h00});
    bus.flags = 8'h01;
    repeat (2) @(negedge clk);
    chk_reset("reset_values");
    rst = 1'b0;
    #1 chk("c1_fetch", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h00});
    @(negedge clk) chk("c2_decode", {bus.rw, bus.wen, bus.ri_d, bus.wd}, {1'b0, 1'b1, 3'd3, 8'h5A});
    @(negedge clk) chk("c3_execute", {bus.rw, bus.wen, bus.ri_d, bus.wd}, {1'b1, 1'b1, 3'd3, 8'h5A});
    @(negedge clk) chk("c4_addr", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h01});
    next_fetch(8'h02, "alu_fetch");
    for (int i = 0; i < 4; i++) begin
      chk("alu_wait_hold", {bus.imem_req, bus.imem_valid, bus.imem_addr}, {1'b1, 1'b0, 8'h02});
      @(negedge clk);
    end
    chk("alu_accept", {bus.imem_req, bus.imem_valid, bus.imem_addr}, {1'b1, 1'b1, 8'h02});
    @(negedge clk) chk("alu_req_drop", {63'd0, bus.imem_req}, 64'd0);
    next_fetch(8'h03, "cmp_fetch");
    chk("alu_rw_once", rw_cnt, 2);
    next_fetch(8'h04, "jz_fetch");
    next_fetch(8'h40, "jz_taken");
    bus.flags = 8'h00;
    next_fetch(8'h41, "jz2_fetch");
    next_fetch(8'h42, "jz_not_taken");
    bus.flags = 8'h02;
    next_fetch(8'h80, "jc_taken");
    next_fetch(8'hFF, "jmp_ff");
    next_fetch(8'h00, "pc_wrap");
    rst = 1'b1;
    chk("no_write_cmp_branch", rw_cnt, 2);
    mem[8'h00] = 16'h4005;
    mem[8'h05] = 16'h9000;
    @(negedge clk) rst = 1'b0;
    #1 chk("restart_fetch", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h00});
    next_fetch(8'h05, "jmp5");
    @(negedge clk);
    @(negedge clk) chk("halt_exec", {63'd0, bus.halted}, 64'd0);
    @(negedge clk) chk("illegal_halt", {bus.halted, bus.illegal, bus.imem_req, bus.rw, bus.imem_addr},
                       {1'b1, 1'b1, 1'b0, 1'b0, 8'h05});
    repeat (3) @(negedge clk);
    chk("halt_hold", {bus.halted, bus.illegal, bus.imem_req, bus.rw, bus.imem_addr},
        {1'b1, 1'b1, 1'b0, 1'b0, 8'h05});
    rst = 1'b1;
    mem[8'h00] = 16'h4010;
    mem[8'h10] = 16'h25A5;
    q.push_back('{wen: 1'b1, op: 3'd0, rd: 3'd5, ra: 3'd0, rb: 3'd0, wd: 8'hA5});
    @(negedge clk) chk_reset("reset_after_halt");
    rst = 1'b0;
    #1 chk("restart_after_halt", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h00});
    next_fetch(8'h10, "ldi_fetch");
    @(negedge clk);
    @(negedge clk) chk("ldi_exec_rw", {63'd0, bus.rw}, 64'd1);
    rst = 1'b1;
    @(negedge clk) chk("abort_rw_low", {bus.rw, bus.imem_req, bus.imem_addr}, {1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    #1 chk("abort_refetch", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h00});
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control unit that drives the register/ALU datapath from a stored program: fetches 16-bit instructions over a request/valid memory port, decodes them, and issues the datapath control signals. Its outputs are alu_op, ri_a, ri_b, ri_d, rw, wen and wd; it reads back the datapath's flags for conditional branches. It sits between the instruction memory and the datapath, and it is the only master of the datapath control inputs.

## Interface
- RESET_PC, 8'h00, program counter value loaded on reset
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- imem_addr  output  8  instruction address (equals pc)
- imem_req  output  1  fetch request, high for the whole FETCH state
- imem_data  input  16  instruction word, sampled when imem_valid=1 in FETCH
- imem_valid  input  1  instruction word valid; any latency ≥0 cycles after req
- flags  input  8  datapath flags; bit0 = zero, bit1 = carry
- alu_op  output  3  ALU operation to datapath
- ri_a, ri_b, ri_d  output  3 each  register indices (source A, source B, destination)
- rw  output  1  register-bank write strobe, one cycle per writing instruction
- wen  output  1  selects wd (1) or ALU result (0) as write data
- wd  output  8  immediate write data
- halted  output  1  high while in HALT
- illegal  output  1  sticky; set when an undefined opcode is decoded

## Operation
- Instruction format: opcode = ir[15:12].
  - 0x0 NOP: no datapath effect.
  - 0x1 ALU: alu_op=ir[11:9], ri_d=ir[8:6], ri_a=ir[5:3], ri_b=ir[2:0], rw=1, wen=0.
  - 0x2 LDI: ri_d=ir[10:8], wd=ir[7:0], rw=1, wen=1.
  - 0x3 CMP: same fields as ALU; rw=0 (flags only).
  - 0x4 JMP: pc ← ir[7:0].
  - 0x5 JZ: pc ← ir[7:0] if flags[0], else pc+1.
  - 0x6 JC: pc ← ir[7:0] if flags[1], else pc+1.
  - 0xF HALT.
  - All other opcodes: illegal ← 1, enter HALT.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid: ir ← imem_data, go to DECODE.
  - DECODE: field outputs (alu_op, ri_*, wd, wen) take ir's values.
  - EXECUTE: rw asserted as decoded; pc updated (pc+1 or branch target); go to FETCH. HALT and illegal opcodes go to HALT instead of FETCH, with pc unchanged.
  - HALT: terminal until rst; every output holds except rw=0 and imem_req=0.
- Field outputs alu_op, ri_a, ri_b, ri_d, wd and wen are registered. They are stable from DECODE through EXECUTE and hold until the next DECODE.
- Field outputs that an opcode does not use are driven to 0.
- rw is high only in EXECUTE of ALU/LDI.
- pc arithmetic is 8-bit modulo: 8'hFF+1 → 8'h00. A branch target of any value is legal.
- Branches evaluate flags during their EXECUTE cycle. The datapath latches flags at negedge, so a JZ/JC immediately after a CMP/ALU sees that instruction's result.

## Timing
- Reset values:
  - state=FETCH, pc=RESET_PC.
  - imem_req=0 during the reset cycle, 1 on the first cycle after rst deasserts.
  - rw=0, wen=0, wd=0, alu_op=0, ri_a=ri_b=ri_d=0, halted=0, illegal=0.
- Reset mid-instruction: rst at any edge aborts the instruction. rw is low from the next cycle and no partial write is issued.
- Latency with zero-wait memory (imem_valid in first FETCH cycle): 3 cycles per instruction (FETCH, DECODE, EXECUTE). Each wait cycle adds 1.
- imem_valid outside FETCH is ignored. imem_req drops in the cycle after valid is accepted.
- imem_addr is constant while imem_req=1.
- halted rises in the cycle after EXECUTE of HALT or of an illegal opcode. illegal rises in that same cycle.

## Test plan
- Reset then LDI r3,0x5A at addr 0, zero-wait:
  - rw=1, wen=1, ri_d=3, wd=0x5A in cycle 3.
  - imem_addr=1 in cycle 4.
- ALU op=2, rd=1, ra=2, rb=3 with imem_valid delayed 4 cycles:
  - rw pulses exactly once, for 1 cycle, with wen=0, alu_op=2, ri_d=1, ri_a=2, ri_b=3.
  - imem_addr is held throughout the wait.
- CMP then JZ 0x40:
  - flags=0x01 → next imem_addr=0x40.
  - flags=0x00 → next imem_addr=pc+1.
  - rw stays 0 for both instructions.
- JMP 0xFF, then NOP at 0xFF → next fetch address 0x00 (wrap).
- Opcode 0x9 at addr 5:
  - illegal=1, halted=1, imem_req=0 thereafter, pc held at 5.
  - rst → all outputs return to reset values and fetch restarts at RESET_PC.
- rst asserted during EXECUTE of an LDI → rw=0 from the next cycle, pc=RESET_PC, FETCH resumes.
